// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and width helpers for the HUB75 BCM timing engine.
//   state_t     - timing FSM states
//   plane_ptr_t - bit-plane pointer {row, plane}; fields are 16 bits wide and
//                 users slice them down to ROW_W / BIT_W
//   row_width / bit_width / disp_width / max3 - derived width helpers
package hub75_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        BLANK,
        LATCH,
        DISPLAY,
        STALL
    } state_t;

    localparam int PTR_FIELD_W = 16;

    typedef struct packed {
        logic [PTR_FIELD_W-1:0] row;
        logic [PTR_FIELD_W-1:0] plane;
    } plane_ptr_t;

    function automatic int row_width(input int num_rows);
        return (num_rows > 2) ? $clog2(num_rows) : 1;
    endfunction

    function automatic int bit_width(input int color_bits);
        return (color_bits > 2) ? $clog2(color_bits) : 1;
    endfunction

    // Wide enough to hold the longest on-time, BASE_TICKS << (COLOR_BITS-1).
    function automatic int disp_width(input int base_ticks, input int color_bits);
        return $clog2((base_ticks << (color_bits - 1)) + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hub75_plane_counter.sv
// hub75_plane_counter: bit-plane pointer for BCM scan order.
//   Order is row r bits 0..COLOR_BITS-1, then row r+1; the last plane wraps
//   back to (0,0).
// Ports:
//   clk, rst    - clock, synchronous active-high reset (pointer -> (0,0))
//   advance     - step the pointer to the next plane
//   row, plane  - current pointer (plane to be requested next)
//   frame_wrap  - high while the pointer sits at (0,0) (after reset or wrap)
module hub75_plane_counter
    import hub75_pkg::*;
#(
    parameter int COLOR_BITS = 8,
    parameter int NUM_ROWS   = 16,
    parameter int ROW_W      = row_width(NUM_ROWS),
    parameter int BIT_W      = bit_width(COLOR_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [BIT_W-1:0] plane,
    output logic             frame_wrap
);

    plane_ptr_t ptr;
    logic       last_plane;
    logic       last_row;

    always_comb begin
        last_plane = (ptr.plane == PTR_FIELD_W'(COLOR_BITS - 1));
        last_row   = (ptr.row == PTR_FIELD_W'(NUM_ROWS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            frame_wrap <= 1'b1;
        end else if (advance) begin
            frame_wrap <= last_plane && last_row;
            if (last_plane) begin
                ptr.plane <= '0;
                ptr.row   <= last_row ? '0 : ptr.row + PTR_FIELD_W'(1);
            end else begin
                ptr.plane <= ptr.plane + PTR_FIELD_W'(1);
            end
        end
    end

    assign row   = ptr.row[ROW_W-1:0];
    assign plane = ptr.plane[BIT_W-1:0];

endmodule

// File: rtl/hub75_bcm_timing.sv
// hub75_bcm_timing: HUB75 panel timing engine for binary-coded modulation.
//   One FSM sequences row address, latch and OE for every bit-plane of every
//   scan row, and requests the next plane from the column shifter while the
//   current one is being displayed.
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   brightness [7:0]   - global dimming (only with HUB75_BRIGHTNESS_EN)
//   en                 - run enable; low finishes the current plane then idles
//   shift_req          - 1-cycle pulse: shifter loads plane (req_row, req_bit)
//   req_row, req_bit   - plane of the last request, held until the next one
//   shift_done         - 1-cycle pulse from shifter: requested plane loaded
//   row_addr           - panel row address
//   latch              - panel LAT (active high)
//   oe                 - panel OE (active low)
//   frame_sync         - pulses with the request for plane (0,0)
//   busy               - high whenever the FSM is not IDLE
// Build option: define HUB75_BRIGHTNESS_EN to add the brightness port; OE is
//   then held low only for max(1, on_ticks*(brightness+1)>>8) cycles of each
//   DISPLAY while the DISPLAY length itself is unchanged.
module hub75_bcm_timing
    import hub75_pkg::*;
#(
    parameter int COLOR_BITS  = 8,
    parameter int NUM_ROWS    = 16,
    parameter int BASE_TICKS  = 32,
    parameter int BLANK_TICKS = 4,
    parameter int LATCH_TICKS = 1,
    localparam int ROW_W  = row_width(NUM_ROWS),
    localparam int BIT_W  = bit_width(COLOR_BITS),
    localparam int DISP_W = disp_width(BASE_TICKS, COLOR_BITS)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef HUB75_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    input  logic             en,
    output logic             shift_req,
    output logic [ROW_W-1:0] req_row,
    output logic [BIT_W-1:0] req_bit,
    input  logic             shift_done,
    output logic [ROW_W-1:0] row_addr,
    output logic             latch,
    output logic             oe,
    output logic             frame_sync,
    output logic             busy
);

    // One shared phase counter covers BLANK, LATCH and DISPLAY.
    localparam int CNT_W = max3(DISP_W, $clog2(BLANK_TICKS + 1), $clog2(LATCH_TICKS + 1));

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DISP_W-1:0] on_len;
    logic [DISP_W-1:0] on_ticks;
    logic              outstanding;
    logic              next_ready;
    logic              req_issued;
    logic              accept;
    logic              issue;
    logic              blank_end;
    logic              latch_end;
    logic              disp_end;

    logic [ROW_W-1:0]  ptr_row;
    logic [BIT_W-1:0]  ptr_bit;
    logic              ptr_origin;

`ifdef HUB75_BRIGHTNESS_EN
    localparam int EFF_W = DISP_W + 8;
    logic [EFF_W-1:0]  prod;
    logic [EFF_W-1:0]  scaled;
    logic [EFF_W-1:0]  eff_calc;
    logic [EFF_W-1:0]  eff_q;
    logic [EFF_W-1:0]  eff_now;
    logic              first_disp;

    always_comb begin
        prod     = EFF_W'(on_len) * EFF_W'({1'b0, brightness} + 9'd1);
        scaled   = prod >> 8;
        eff_calc = (scaled == '0) ? EFF_W'(1) : scaled;
        // brightness is taken on the first DISPLAY cycle and held after that
        eff_now  = first_disp ? eff_calc : eff_q;
    end
`endif

    always_comb begin
        // shift_done only counts once its request has been visible for a cycle
        accept    = shift_done && outstanding && !shift_req;
        blank_end = (cnt == CNT_W'(BLANK_TICKS - 1));
        latch_end = (cnt == CNT_W'(LATCH_TICKS - 1));
        disp_end  = (cnt == (CNT_W'(on_len) - CNT_W'(1)));
        // requests leave IDLE, or go out as the next DISPLAY starts
        issue     = en && ((state == IDLE) || ((state == LATCH) && latch_end));
        on_ticks  = DISP_W'(BASE_TICKS) << req_bit;
    end

    hub75_plane_counter #(
        .COLOR_BITS (COLOR_BITS),
        .NUM_ROWS   (NUM_ROWS),
        .ROW_W      (ROW_W),
        .BIT_W      (BIT_W)
    ) u_planes (
        .clk        (clk),
        .rst        (rst),
        .advance    (issue),
        .row        (ptr_row),
        .plane      (ptr_bit),
        .frame_wrap (ptr_origin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            on_len      <= '0;
            outstanding <= 1'b0;
            next_ready  <= 1'b0;
            req_issued  <= 1'b0;
            shift_req   <= 1'b0;
            req_row     <= '0;
            req_bit     <= '0;
            frame_sync  <= 1'b0;
            row_addr    <= '0;
            latch       <= 1'b0;
            oe          <= 1'b1;
            busy        <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
            first_disp  <= 1'b0;
            eff_q       <= '0;
`endif
        end else begin
            shift_req  <= issue;
            frame_sync <= issue && ptr_origin;
            if (issue) begin
                req_row     <= ptr_row;
                req_bit     <= ptr_bit;
                outstanding <= 1'b1;
            end else if (accept) begin
                outstanding <= 1'b0;
            end

            case (state)
                IDLE: begin
                    oe    <= 1'b1;
                    latch <= 1'b0;
                    if (en) begin
                        state <= PRIME;
                        busy  <= 1'b1;
                    end
                end

                PRIME: begin
                    if (accept) begin
                        state    <= BLANK;
                        cnt      <= '0;
                        row_addr <= req_row;
                    end
                end

                BLANK: begin
                    if (blank_end) begin
                        state <= LATCH;
                        cnt   <= '0;
                        latch <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                LATCH: begin
                    if (latch_end) begin
                        // on_len captures the plane being latched now; req_bit
                        // moves on to the next plane on this same edge
                        state      <= DISPLAY;
                        cnt        <= '0;
                        latch      <= 1'b0;
                        oe         <= 1'b0;
                        on_len     <= on_ticks;
                        req_issued <= issue;
                        next_ready <= 1'b0;
`ifdef HUB75_BRIGHTNESS_EN
                        first_disp <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DISPLAY: begin
`ifdef HUB75_BRIGHTNESS_EN
                    first_disp <= 1'b0;
`endif
                    if (accept) begin
                        next_ready <= 1'b1;
                    end
                    if (disp_end) begin
                        oe <= 1'b1;
                        if (!req_issued) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (next_ready || accept) begin
                            state      <= BLANK;
                            cnt        <= '0;
                            row_addr   <= req_row;
                            next_ready <= 1'b0;
                        end else begin
                            state <= STALL;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
`ifdef HUB75_BRIGHTNESS_EN
                        if (first_disp) begin
                            eff_q <= eff_calc;
                        end
                        oe <= !((EFF_W'(cnt) + EFF_W'(1)) < eff_now);
`endif
                    end
                end

                STALL: begin
                    if (accept) begin
                        state      <= BLANK;
                        cnt        <= '0;
                        row_addr   <= req_row;
                        next_ready <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    oe    <= 1'b1;
                    latch <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
